// File: rtl/pcpu_fetch_bp.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and a direct-mapped
// branch history/target table of 2-bit saturating counters with EX-stage resolution.
module pcpu_fetch_bp #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       BHT_DEPTH   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter bit                ENABLE_PRED = 1'b1,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              inst_ready,
  input  logic [31:0]       inst_in,
  output logic [ADDR_W-1:0] pc_out,
  output logic              if_valid,
  output logic [31:0]       if_inst,
  output logic [ADDR_W-1:0] if_pc,
  output logic              if_pred_taken,
  output logic [ADDR_W-1:0] if_pred_target,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              ex_pred_taken,
  input  logic [ADDR_W-1:0] ex_pred_target,
  output logic              redirect,
  output logic [CNT_W-1:0]  mispredict_cnt
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [ADDR_W-1:0] PcStep = ADDR_W'(4);

  // Branch table state, one array per entry field
  logic [BHT_DEPTH-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q [BHT_DEPTH];
  logic [TAG_W-1:0]     tag_d [BHT_DEPTH];
  logic [1:0]           ctr_q [BHT_DEPTH];
  logic [1:0]           ctr_d [BHT_DEPTH];
  logic [ADDR_W-1:0]    tgt_q [BHT_DEPTH];
  logic [ADDR_W-1:0]    tgt_d [BHT_DEPTH];

  // Fetch and IF/ID state
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              if_valid_q, if_valid_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic              if_ptk_q, if_ptk_d;
  logic [ADDR_W-1:0] if_ptgt_q, if_ptgt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Lookup on the current fetch address
  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_tgt;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] pred_next;

  always_comb begin
    lk_idx     = pc_q[IDX_W+1:2];
    lk_tag     = pc_q[ADDR_W-1:IDX_W+2];
    lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken = ENABLE_PRED && lk_hit && ctr_q[lk_idx][1];
    pred_tgt   = tgt_q[lk_idx];
    pc_plus4   = pc_q + PcStep;
    pred_next  = pred_taken ? pred_tgt : pc_plus4;
  end

  // Resolution from EX
  logic              mispredict;
  logic [ADDR_W-1:0] fix_pc;

  always_comb begin
    mispredict = ex_valid && ex_is_branch &&
                 ((ex_taken != ex_pred_taken) ||
                  (ex_taken && (ex_target != ex_pred_target)));
    fix_pc     = ex_taken ? ex_target : (ex_pc + PcStep);
  end

  assign redirect = mispredict;

  // Table update, indexed by the resolving instruction's PC
  logic             up_en;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;

  always_comb begin
    up_en  = ENABLE_PRED && ex_valid && ex_is_branch;
    up_idx = ex_pc[IDX_W+1:2];
    up_tag = ex_pc[ADDR_W-1:IDX_W+2];
    up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  end

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    ctr_d   = ctr_q;
    tgt_d   = tgt_q;
    if (up_en) begin
      if (up_hit) begin
        if (ex_taken) begin
          if (ctr_q[up_idx] != 2'b11) ctr_d[up_idx] = ctr_q[up_idx] + 2'b01;
          tgt_d[up_idx] = ex_target;
        end else if (ctr_q[up_idx] != 2'b00) begin
          ctr_d[up_idx] = ctr_q[up_idx] - 2'b01;
        end
      end else if (ex_taken) begin
        // Fresh allocation starts weakly taken so the next fetch follows it
        valid_d[up_idx] = 1'b1;
        tag_d[up_idx]   = up_tag;
        ctr_d[up_idx]   = 2'b10;
        tgt_d[up_idx]   = ex_target;
      end
    end
  end

  // PC and IF/ID next state: redirect > stall > wait state > normal fetch
  always_comb begin
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_inst_d  = if_inst_q;
    if_pc_d    = if_pc_q;
    if_ptk_d   = if_ptk_q;
    if_ptgt_d  = if_ptgt_q;
    if (mispredict) begin
      pc_d       = fix_pc;
      if_valid_d = 1'b0;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (!inst_ready) begin
      if_valid_d = 1'b0;
    end else begin
      pc_d       = pred_next;
      if_valid_d = 1'b1;
      if_inst_d  = inst_in;
      if_pc_d    = pc_q;
      if_ptk_d   = pred_taken;
      if_ptgt_d  = pred_taken ? pred_tgt : '0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (mispredict && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_inst_q  <= '0;
      if_pc_q    <= '0;
      if_ptk_q   <= 1'b0;
      if_ptgt_q  <= '0;
      cnt_q      <= '0;
      valid_q    <= '0;
      for (int i = 0; i < BHT_DEPTH; i++) begin
        tag_q[i] <= '0;
        ctr_q[i] <= 2'b01;
        tgt_q[i] <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_inst_q  <= if_inst_d;
      if_pc_q    <= if_pc_d;
      if_ptk_q   <= if_ptk_d;
      if_ptgt_q  <= if_ptgt_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      ctr_q      <= ctr_d;
      tgt_q      <= tgt_d;
    end
  end

  assign pc_out         = pc_q;
  assign if_valid       = if_valid_q;
  assign if_inst        = if_inst_q;
  assign if_pc          = if_pc_q;
  assign if_pred_taken  = if_ptk_q;
  assign if_pred_target = if_ptgt_q;
  assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_pcpu_fetch_bp.sv
// Bench for pcpu_fetch_bp: a predicting instance and a non-predicting one with a narrow
// statistics counter, checked every cycle against a table-level model plus literal pins.
module tb_pcpu_fetch_bp;

  localparam int unsigned Depth = 64;
  localparam int unsigned IdxSh = 8;  // log2(Depth) + 2

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        stall [2], inst_ready [2], ex_valid [2], ex_is_branch [2];
  logic        ex_taken [2], ex_pred_taken [2];
  logic [31:0] inst_in [2], ex_pc [2], ex_target [2], ex_pred_target [2];
  logic [31:0] pc_out [2], if_inst [2], if_pc [2], if_pred_target [2];
  logic        if_valid [2], if_pred_taken [2], redirect [2];
  logic [15:0] cnt0;
  logic [2:0]  cnt1;
  logic [31:0] cnt_w [2];
  assign cnt_w[0] = {16'b0, cnt0};
  assign cnt_w[1] = {29'b0, cnt1};

  pcpu_fetch_bp #(
    .ADDR_W(32), .BHT_DEPTH(64), .RESET_PC(32'h0), .ENABLE_PRED(1'b1), .CNT_W(16)
  ) u_dut0 (
    .clk(clk), .reset(reset), .stall(stall[0]), .inst_ready(inst_ready[0]),
    .inst_in(inst_in[0]), .pc_out(pc_out[0]), .if_valid(if_valid[0]),
    .if_inst(if_inst[0]), .if_pc(if_pc[0]), .if_pred_taken(if_pred_taken[0]),
    .if_pred_target(if_pred_target[0]), .ex_valid(ex_valid[0]),
    .ex_is_branch(ex_is_branch[0]), .ex_taken(ex_taken[0]), .ex_pc(ex_pc[0]),
    .ex_target(ex_target[0]), .ex_pred_taken(ex_pred_taken[0]),
    .ex_pred_target(ex_pred_target[0]), .redirect(redirect[0]), .mispredict_cnt(cnt0)
  );

  pcpu_fetch_bp #(
    .ADDR_W(32), .BHT_DEPTH(64), .RESET_PC(32'h100), .ENABLE_PRED(1'b0), .CNT_W(3)
  ) u_dut1 (
    .clk(clk), .reset(reset), .stall(stall[1]), .inst_ready(inst_ready[1]),
    .inst_in(inst_in[1]), .pc_out(pc_out[1]), .if_valid(if_valid[1]),
    .if_inst(if_inst[1]), .if_pc(if_pc[1]), .if_pred_taken(if_pred_taken[1]),
    .if_pred_target(if_pred_target[1]), .ex_valid(ex_valid[1]),
    .ex_is_branch(ex_is_branch[1]), .ex_taken(ex_taken[1]), .ex_pc(ex_pc[1]),
    .ex_target(ex_target[1]), .ex_pred_taken(ex_pred_taken[1]),
    .ex_pred_target(ex_pred_target[1]), .redirect(redirect[1]), .mispredict_cnt(cnt1)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;
  int seq    = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          v;
    logic [31:0] tag;
    int          ctr;
    logic [31:0] tgt;
  } ent_t;

  ent_t        tbl [2][Depth];
  logic [31:0] m_pc [2], m_ifinst [2], m_ifpc [2], m_ptgt [2];
  bit          m_ifv [2], m_ptk [2];
  int          m_cnt [2];

  function automatic bit m_misp(input int n);
    return ex_valid[n] && ex_is_branch[n] &&
           ((ex_taken[n] != ex_pred_taken[n]) ||
            (ex_taken[n] && (ex_target[n] != ex_pred_target[n])));
  endfunction

  task automatic m_reset();
    for (int n = 0; n < 2; n++) begin
      m_pc[n]    = (n == 0) ? 32'h0 : 32'h100;
      m_ifv[n]   = 1'b0;
      m_ifinst[n] = '0;
      m_ifpc[n]  = '0;
      m_ptk[n]   = 1'b0;
      m_ptgt[n]  = '0;
      m_cnt[n]   = 0;
      for (int i = 0; i < Depth; i++) tbl[n][i] = '{v: 1'b0, tag: '0, ctr: 1, tgt: '0};
    end
  endtask

  task automatic m_step();
    for (int n = 0; n < 2; n++) begin
      bit          en   = (n == 0);
      int          cmax = (n == 0) ? 65535 : 7;
      int          i    = int'((m_pc[n] >> 2) % Depth);
      bit          hit  = tbl[n][i].v && (tbl[n][i].tag == (m_pc[n] >> IdxSh));
      bit          ptk  = en && hit && (tbl[n][i].ctr >= 2);
      logic [31:0] ptgt = tbl[n][i].tgt;
      bit          misp = m_misp(n);
      if (en && ex_valid[n] && ex_is_branch[n]) begin
        int j  = int'((ex_pc[n] >> 2) % Depth);
        bit uh = tbl[n][j].v && (tbl[n][j].tag == (ex_pc[n] >> IdxSh));
        if (uh) begin
          if (ex_taken[n]) begin
            tbl[n][j].ctr = (tbl[n][j].ctr == 3) ? 3 : tbl[n][j].ctr + 1;
            tbl[n][j].tgt = ex_target[n];
          end else begin
            tbl[n][j].ctr = (tbl[n][j].ctr == 0) ? 0 : tbl[n][j].ctr - 1;
          end
        end else if (ex_taken[n]) begin
          tbl[n][j] = '{v: 1'b1, tag: ex_pc[n] >> IdxSh, ctr: 2, tgt: ex_target[n]};
        end
      end
      if (misp) begin
        if (m_cnt[n] < cmax) m_cnt[n]++;
        m_pc[n]  = ex_taken[n] ? ex_target[n] : ex_pc[n] + 32'd4;
        m_ifv[n] = 1'b0;
      end else if (stall[n]) begin
        m_ifv[n] = m_ifv[n];
      end else if (!inst_ready[n]) begin
        m_ifv[n] = 1'b0;
      end else begin
        m_ifv[n]    = 1'b1;
        m_ifinst[n] = inst_in[n];
        m_ifpc[n]   = m_pc[n];
        m_ptk[n]    = ptk;
        m_ptgt[n]   = ptk ? ptgt : 32'h0;
        m_pc[n]     = ptk ? ptgt : m_pc[n] + 32'd4;
      end
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) m_reset();
    else m_step();
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int n = 0; n < 2; n++) begin
        check($sformatf("d%0d.pc_out", n), pc_out[n], m_pc[n]);
        check($sformatf("d%0d.if_valid", n), 32'(if_valid[n]), 32'(m_ifv[n]));
        check($sformatf("d%0d.if_inst", n), if_inst[n], m_ifinst[n]);
        check($sformatf("d%0d.if_pc", n), if_pc[n], m_ifpc[n]);
        check($sformatf("d%0d.if_pred_taken", n), 32'(if_pred_taken[n]), 32'(m_ptk[n]));
        check($sformatf("d%0d.if_pred_target", n), if_pred_target[n], m_ptgt[n]);
        check($sformatf("d%0d.redirect", n), 32'(redirect[n]), 32'(m_misp(n)));
        check($sformatf("d%0d.mispredict_cnt", n), cnt_w[n], 32'(m_cnt[n]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
    seq++;
    inst_in[0] = {16'hC0DE, 16'(seq)};
    inst_in[1] = {16'hBEEF, 16'(seq)};
  endtask

  task automatic br(input int n, input bit tk, input logic [31:0] pc, input logic [31:0] tgt,
                    input bit ptk, input logic [31:0] ptgt);
    ex_valid[n]       = 1'b1;
    ex_is_branch[n]   = 1'b1;
    ex_taken[n]       = tk;
    ex_pc[n]          = pc;
    ex_target[n]      = tgt;
    ex_pred_taken[n]  = ptk;
    ex_pred_target[n] = ptgt;
  endtask

  task automatic clr(input int n);
    ex_valid[n]     = 1'b0;
    ex_is_branch[n] = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    for (int n = 0; n < 2; n++) begin
      stall[n] = 1'b0; inst_ready[n] = 1'b1; inst_in[n] = 32'h0;
      ex_valid[n] = 1'b0; ex_is_branch[n] = 1'b0; ex_taken[n] = 1'b0;
      ex_pc[n] = '0; ex_target[n] = '0; ex_pred_taken[n] = 1'b0; ex_pred_target[n] = '0;
    end
    m_reset();
    #1 reset = 1'b0;
    @(posedge clk);
    #2;
    check("rst.pc0", pc_out[0], 32'h0);
    check("rst.pc1", pc_out[1], 32'h100);
    check("rst.if_valid", 32'(if_valid[0]), 32'h0);
    check("rst.cnt", cnt_w[0], 32'h0);
    reset = 1'b1;
    chk_en = 1'b1;

    repeat (9) tick();
    check("run.pc_24", pc_out[0], 32'h24);
    // Asynchronous reset mid-run
    reset = 1'b0;
    #1;
    check("arst.pc", pc_out[0], 32'h0);
    check("arst.if_valid", 32'(if_valid[0]), 32'h0);
    check("arst.cnt", cnt_w[0], 32'h0);
    #1 reset = 1'b1;
    tick();
    check("rel.pc_4", pc_out[0], 32'h4);
    check("rel.if_pc_0", if_pc[0], 32'h0);
    tick();
    check("rel.pc_8", pc_out[0], 32'h8);
    check("rel.if_pc_4", if_pc[0], 32'h4);

    // Instruction-memory wait states
    inst_ready[0] = 1'b0;
    repeat (2) begin
      tick();
      check("wait.pc", pc_out[0], 32'h8);
      check("wait.if_valid", 32'(if_valid[0]), 32'h0);
    end
    inst_ready[0] = 1'b1;
    tick();
    check("wait.if_pc", if_pc[0], 32'h8);
    check("wait.pc_c", pc_out[0], 32'hC);
    tick();
    tick();
    check("br.if_pc_10", if_pc[0], 32'h10);

    // First taken branch 0x10 -> 0x40, nothing predicted
    br(0, 1'b1, 32'h10, 32'h40, 1'b0, 32'h0);
    #1 check("br1.redirect", 32'(redirect[0]), 32'h1);
    tick();
    check("br1.pc", pc_out[0], 32'h40);
    check("br1.cnt", cnt_w[0], 32'h1);
    br(0, 1'b1, 32'h44, 32'h10, 1'b0, 32'h0);
    tick();
    clr(0);
    check("jb.pc", pc_out[0], 32'h10);
    tick();
    check("br2.pc", pc_out[0], 32'h40);
    check("br2.pred_taken", 32'(if_pred_taken[0]), 32'h1);
    check("br2.pred_target", if_pred_target[0], 32'h40);

    // Correctly predicted resolutions, then a not-taken mispredict
    br(0, 1'b1, 32'h10, 32'h40, 1'b1, 32'h40);
    #1 check("train.redirect", 32'(redirect[0]), 32'h0);
    tick();
    tick();
    br(0, 1'b0, 32'h10, 32'h40, 1'b1, 32'h40);
    #1 check("nt.redirect", 32'(redirect[0]), 32'h1);
    tick();
    check("nt.pc", pc_out[0], 32'h14);
    br(0, 1'b1, 32'h200, 32'h10, 1'b0, 32'h0);
    tick();
    clr(0);
    tick();
    check("nt.still_pred_pc", pc_out[0], 32'h40);
    check("nt.still_pred", 32'(if_pred_taken[0]), 32'h1);

    // Alias at the same index with a different tag
    br(0, 1'b1, 32'h300, 32'h110, 1'b0, 32'h0);
    tick();
    clr(0);
    tick();
    check("alias.pc", pc_out[0], 32'h114);
    check("alias.pred", 32'(if_pred_taken[0]), 32'h0);

    // Redirect outranks stall and wait state
    stall[0] = 1'b1;
    inst_ready[0] = 1'b0;
    br(0, 1'b1, 32'h400, 32'h80, 1'b0, 32'h0);
    tick();
    clr(0);
    check("prio.pc", pc_out[0], 32'h80);
    check("prio.if_valid", 32'(if_valid[0]), 32'h0);
    stall[0] = 1'b0;
    inst_ready[0] = 1'b1;
    tick();
    stall[0] = 1'b1;
    repeat (2) tick();
    check("stall.pc", pc_out[0], 32'h84);
    check("stall.if_pc", if_pc[0], 32'h80);
    stall[0] = 1'b0;

    // PC wrap and a wrong-target mispredict
    br(0, 1'b1, 32'h500, 32'hFFFF_FFFC, 1'b0, 32'h0);
    tick();
    clr(0);
    tick();
    check("wrap.pc", pc_out[0], 32'h0);
    check("wrap.if_pc", if_pc[0], 32'hFFFF_FFFC);
    br(0, 1'b1, 32'h10, 32'h60, 1'b1, 32'h40);
    #1 check("tgt.redirect", 32'(redirect[0]), 32'h1);
    tick();
    clr(0);
    check("tgt.pc", pc_out[0], 32'h60);
    check("tgt.cnt", cnt_w[0], 32'h8);

    // Non-predicting instance: every taken branch redirects, counter saturates at 7
    br(1, 1'b1, 32'h100, 32'h40, 1'b0, 32'h0);
    repeat (9) begin
      #1 check("np.redirect", 32'(redirect[1]), 32'h1);
      tick();
      check("np.pc", pc_out[1], 32'h40);
    end
    clr(1);
    check("np.cnt_sat", cnt_w[1], 32'h7);
    tick();
    check("np.no_pred", pc_out[1], 32'h44);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pcpu_fetch_bp.md
Name: pcpu_fetch_bp

Overview:
Parametrised instruction-fetch stage for the 5-stage pipelined CPU. It combines the PC register, the IF/ID pipeline register and a direct-mapped branch history/target table of 2-bit saturating counters. It predicts next-PC in IF, accepts branch resolution from EX, and issues a redirect/flush on mispredict. It also honours instruction-memory wait states and pipeline stalls.

Parameters:
ADDR_W, 32, PC/address width in bits (>= IDX_W+3)
BHT_DEPTH, 64, table entries, power of two; IDX_W = log2(BHT_DEPTH)
RESET_PC, 0, PC value loaded on reset
ENABLE_PRED, 1, 0 = always predict not-taken and never write the table
CNT_W, 16, width of mispredict statistics counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  hazard stall: hold PC and IF/ID
inst_ready  in  1  instruction memory has valid data for pc_out this cycle
inst_in  in  32  instruction word for pc_out
pc_out  out  ADDR_W  fetch address to instruction memory
if_valid  out  1  IF/ID register holds a real instruction
if_inst  out  32  IF/ID instruction
if_pc  out  ADDR_W  IF/ID PC of that instruction
if_pred_taken  out  1  prediction made for that instruction
if_pred_target  out  ADDR_W  predicted target (0 if not taken)
ex_valid  in  1  EX stage holds a resolving control-transfer instruction
ex_is_branch  in  1  EX instruction is a branch or jump
ex_taken  in  1  actual outcome
ex_pc  in  ADDR_W  PC of EX instruction
ex_target  in  ADDR_W  actual target
ex_pred_taken  in  1  prediction carried down the pipe
ex_pred_target  in  ADDR_W  predicted target carried down the pipe
redirect  out  1  combinational; flush IF/ID and ID/EX this cycle
mispredict_cnt  out  CNT_W  saturating count of redirects

Behaviour:
- Reset (reset=0, asynchronous): pc_out=RESET_PC; if_valid=0; if_inst, if_pc, if_pred_*=0; mispredict_cnt=0; all entries valid=0, counter=2'b01, tag/target=0.
- Entry = {valid, tag, ctr[1:0], target}. idx=pc[IDX_W+1:2]; tag=pc[ADDR_W-1:IDX_W+2].
- Lookup is combinational on pc_out. hit = valid & tag match. pred_taken = ENABLE_PRED & hit & ctr[1]. pred_next = pred_taken ? target : pc_out+4 (mod 2^ADDR_W).
- Mispredict = ex_valid & ex_is_branch & ((ex_taken != ex_pred_taken) | (ex_taken & ex_target != ex_pred_target)). redirect = mispredict.
- Next-state priority per clock edge:
  1. redirect: pc_out <= ex_taken ? ex_target : ex_pc+4; if_valid <= 0. Overrides stall and inst_ready.
  2. stall: pc_out and all IF/ID outputs hold.
  3. !inst_ready: pc_out holds; if_valid <= 0 (bubble).
  4. Normal: pc_out <= pred_next; IF/ID <= {1, inst_in, pc_out, pred_taken, pred_taken ? target : 0}.
- Fetch latency: the instruction at pc_out appears on if_* on the next edge.
- Table update at the clock edge when ex_valid & ex_is_branch & ENABLE_PRED, indexed by ex_pc:
  - Hit: ctr saturating +1 if taken, -1 if not (bounds 00/11). If taken, target <= ex_target.
  - Miss and taken: allocate valid=1, tag, target=ex_target, ctr=2'b10. Miss and not taken: no write.
- A same-cycle lookup and update to one index sees the old entry; write-first is not used.
- mispredict_cnt increments on each redirect cycle and saturates at all-ones.
- ENABLE_PRED=0: every taken branch/jump redirects; the table stays at reset values.
- Reset asserted mid-operation discards in-flight prediction and update; there is no partial table state.

Test Plan:
- Assert reset=0 mid-run at pc_out=0x24 -> immediately pc_out=0, if_valid=0, mispredict_cnt=0. Release; next edges -> pc_out 0x4, 0x8; if_pc 0x0, 0x4.
- inst_ready=0 for 2 cycles at pc_out=0x8 -> pc_out stays 0x8, if_valid=0 for 2 cycles. inst_ready=1 -> if_pc=0x8, pc_out=0xC.
- First execution of taken branch at 0x10 to 0x40 (pred 0) -> redirect=1 for 1 cycle, next pc_out=0x40, mispredict_cnt=1, entry 4 ctr=10. Second pass at 0x10 -> next pc_out=0x40, if_pred_taken=1, no redirect.
- Train 0x10 taken 3 times -> ctr=11. One not-taken -> redirect, pc_out=0x14, ctr=10. Next fetch of 0x10 still predicts 0x40.
- Alias 0x110 (idx 4, different tag) after training 0x10 -> pred_taken=0, pc_out advances to 0x114.
- redirect with stall=1 and inst_ready=0 same cycle -> pc_out takes ex_target 0x80, if_valid=0. With ENABLE_PRED=0, repeat the taken branch -> redirect on every pass.
